// File: rtl/two_mode_timer_core_pkg.sv
// Shared types, default limits and helpers for the two-mode min:sec timer.
// The terminal values and field widths are fixed here so every file agrees on them.
package two_mode_timer_core_pkg;

   localparam int DEFAULT_MAX_MIN = 99;
   localparam int DEFAULT_MAX_SEC = 59;
   localparam int FIELD_W         = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_LOAD = 2'd1,
      CNT_INC  = 2'd2,
      CNT_DEC  = 2'd3
   } cnt_cmd_e;

   // Clamp an out-of-range preset field to its limit.
   function automatic logic [FIELD_W-1:0] sat_field(input logic [FIELD_W-1:0] v,
                                                    input logic [FIELD_W-1:0] lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/timer_digit_counter.sv
// One min or sec field: load / hold / increment / decrement with rollover at MAX_VAL.
// value_next is exposed so the parent can spot the terminal value before it is registered.
module timer_digit_counter
   import two_mode_timer_core_pkg::*;
#(
   parameter int MAX_VAL = DEFAULT_MAX_SEC
)(
   input  logic               clk,
   input  logic               rst,
   input  cnt_cmd_e           cmd,
   input  logic [FIELD_W-1:0] load_val,
   output logic [FIELD_W-1:0] value,
   output logic [FIELD_W-1:0] value_next,
   output logic               at_max,
   output logic               at_zero
);

   localparam logic [FIELD_W-1:0] MAX_V = FIELD_W'(MAX_VAL);

   logic [FIELD_W-1:0] val_q;
   logic [FIELD_W-1:0] val_d;

   always_comb begin
      val_d = val_q;
      case (cmd)
         CNT_LOAD: val_d = load_val;
         CNT_INC:  val_d = (val_q >= MAX_V) ? '0 : val_q + 1'b1;
         CNT_DEC:  val_d = (val_q == '0) ? MAX_V : val_q - 1'b1;
         default:  val_d = val_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         val_q <= '0;
      end else begin
         val_q <= val_d;
      end
   end

   assign value      = val_q;
   assign value_next = val_d;
   assign at_max     = (val_q == MAX_V);
   assign at_zero    = (val_q == '0);

endmodule

// File: rtl/two_mode_timer_core.sv
// Stopwatch / countdown timer: IDLE-RUN-PAUSE-DONE control around two digit counters.
// Mode is latched while idle; the done pulse marks the update that lands on the terminal value.
module two_mode_timer_core
   import two_mode_timer_core_pkg::*;
#(
   parameter int MAX_MIN = DEFAULT_MAX_MIN,
   parameter int MAX_SEC = DEFAULT_MAX_SEC
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       mode,
   input  logic       start_stop,
   input  logic       clear,
   input  logic [7:0] preset_min,
   input  logic [7:0] preset_sec,
   output logic [7:0] min_out,
   output logic [7:0] sec_out,
   output logic       running,
   output logic       done
);

   localparam logic [FIELD_W-1:0] MAX_MIN_V = FIELD_W'(MAX_MIN);
   localparam logic [FIELD_W-1:0] MAX_SEC_V = FIELD_W'(MAX_SEC);

   state_e state_q, state_d;
   logic   mode_q, mode_d;
   logic   done_q, done_d;

   cnt_cmd_e           sec_cmd, min_cmd;
   logic [FIELD_W-1:0] load_min, load_sec;
   logic [FIELD_W-1:0] sec_next, min_next;
   logic               sec_at_max, sec_at_zero;
   logic               min_at_max, min_at_zero;
   logic               terminal;
   logic               load_zero;

   // Start value follows the live mode input, since only IDLE ever loads.
   assign load_min  = mode ? sat_field(preset_min, MAX_MIN_V) : '0;
   assign load_sec  = mode ? sat_field(preset_sec, MAX_SEC_V) : '0;
   assign load_zero = (load_min == '0) && (load_sec == '0);

   assign terminal = mode_q ? ((min_next == '0) && (sec_next == '0))
                            : ((min_next == MAX_MIN_V) && (sec_next == MAX_SEC_V));

   always_comb begin
      sec_cmd = CNT_HOLD;
      min_cmd = CNT_HOLD;
      if (clear || (state_q == ST_IDLE)) begin
         sec_cmd = CNT_LOAD;
         min_cmd = CNT_LOAD;
      end else if ((state_q == ST_RUN) && tick) begin
         if (mode_q) begin
            sec_cmd = CNT_DEC;
            if (sec_at_zero) min_cmd = CNT_DEC;
         end else begin
            sec_cmd = CNT_INC;
            if (sec_at_max) min_cmd = CNT_INC;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
         mode_d  = mode;
      end else begin
         case (state_q)
            ST_IDLE: begin
               mode_d = mode;
               if (start_stop) begin
                  if (mode && load_zero) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               // Reaching the terminal value wins over a pause request on the same tick.
               if (tick && terminal) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (start_stop) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (start_stop) state_d = ST_RUN;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   timer_digit_counter #(.MAX_VAL(MAX_SEC)) u_sec (
      .clk        (clk),
      .rst        (rst),
      .cmd        (sec_cmd),
      .load_val   (load_sec),
      .value      (sec_out),
      .value_next (sec_next),
      .at_max     (sec_at_max),
      .at_zero    (sec_at_zero)
   );

   timer_digit_counter #(.MAX_VAL(MAX_MIN)) u_min (
      .clk        (clk),
      .rst        (rst),
      .cmd        (min_cmd),
      .load_val   (load_min),
      .value      (min_out),
      .value_next (min_next),
      .at_max     (min_at_max),
      .at_zero    (min_at_zero)
   );

   assign running = (state_q == ST_RUN);
   assign done    = done_q;

endmodule

// File: tb/tb_two_mode_timer_core.sv
// Bench for two_mode_timer_core: fixed vector table, directed corner sequences,
// then random stimulus against a total-seconds reference model.
module tb_two_mode_timer_core;

   localparam int MAXM = 99;
   localparam int MAXS = 59;
   localparam int TMAX = MAXM * (MAXS + 1) + MAXS;

   localparam int MS_IDLE  = 0;
   localparam int MS_RUN   = 1;
   localparam int MS_PAUSE = 2;
   localparam int MS_DONE  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       mode = 1'b0;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] preset_min = '0;
   logic [7:0] preset_sec = '0;
   logic [7:0] min_out;
   logic [7:0] sec_out;
   logic       running;
   logic       done;

   int total = 0;
   int bad   = 0;

   // Reference model: time as a single seconds count.
   int m_st   = MS_IDLE;
   int m_t    = 0;
   bit m_mode = 1'b0;
   bit m_done = 1'b0;

   two_mode_timer_core #(.MAX_MIN(MAXM), .MAX_SEC(MAXS)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .mode       (mode),
      .start_stop (start_stop),
      .clear      (clear),
      .preset_min (preset_min),
      .preset_sec (preset_sec),
      .min_out    (min_out),
      .sec_out    (sec_out),
      .running    (running),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         t, m, s, c;
      logic [7:0] pm, ps;
      logic [7:0] emin, esec;
      bit         erun, edone;
   } vec_t;

   vec_t vecs [25];

   function automatic vec_t mk(bit t, bit m, bit s, bit c, int pm, int ps,
                               int emin, int esec, bit er, bit ed);
      vec_t v;
      v.t = t; v.m = m; v.s = s; v.c = c;
      v.pm = 8'(pm); v.ps = 8'(ps);
      v.emin = 8'(emin); v.esec = 8'(esec);
      v.erun = er; v.edone = ed;
      return v;
   endfunction

   function automatic void model_reset();
      m_st = MS_IDLE; m_t = 0; m_mode = 1'b0; m_done = 1'b0;
   endfunction

   function automatic void model_step(bit t, bit m, bit s, bit c, int pm, int ps);
      int  ld;
      bit  finished;
      ld = m ? (((pm > MAXM) ? MAXM : pm) * (MAXS + 1) + ((ps > MAXS) ? MAXS : ps)) : 0;
      m_done   = 1'b0;
      finished = 1'b0;
      if (c) begin
         m_st = MS_IDLE; m_mode = m; m_t = ld;
      end else if (m_st == MS_IDLE) begin
         m_mode = m; m_t = ld;
         if (s) begin
            if (m && ld == 0) begin m_st = MS_DONE; m_done = 1'b1; end
            else m_st = MS_RUN;
         end
      end else if (m_st == MS_RUN) begin
         if (t) begin
            m_t = m_mode ? m_t - 1 : m_t + 1;
            if ((m_mode && m_t == 0) || (!m_mode && m_t == TMAX)) begin
               m_st = MS_DONE; m_done = 1'b1; finished = 1'b1;
            end
         end
         if (!finished && s) m_st = MS_PAUSE;
      end else if (m_st == MS_PAUSE) begin
         if (s) m_st = MS_RUN;
      end
   endfunction

   task automatic check(input string name, input int emin, input int esec,
                        input bit erun, input bit edone);
      total++;
      if (min_out !== 8'(emin) || sec_out !== 8'(esec) || running !== erun || done !== edone) begin
         bad++;
         $display("FAIL %s: got %0d:%0d run=%0b done=%0b, want %0d:%0d run=%0b done=%0b",
                  name, min_out, sec_out, running, done, emin, esec, erun, edone);
      end else begin
         $display("ok   %s: %0d:%0d run=%0b done=%0b", name, min_out, sec_out, running, done);
      end
   endtask

   task automatic check_model(input string name);
      check(name, m_t / (MAXS + 1), m_t % (MAXS + 1), m_st == MS_RUN, m_done);
   endtask

   task automatic apply(input bit t, input bit m, input bit s, input bit c,
                        input int pm, input int ps);
      tick = t; mode = m; start_stop = s; clear = c;
      preset_min = 8'(pm); preset_sec = 8'(ps);
      model_step(t, m, s, c, pm, ps);
      @(posedge clk);
      #1;
      tick = 1'b0; start_stop = 1'b0; clear = 1'b0;
   endtask

   initial begin
      //                 t  m  s  c  pm   ps  emin esec run done
      vecs[0]  = mk(0, 1, 0, 0,   1,   0,   1,   0, 0, 0);
      vecs[1]  = mk(0, 1, 1, 0,   1,   0,   1,   0, 1, 0);
      vecs[2]  = mk(1, 1, 0, 0,   1,   0,   0,  59, 1, 0);
      vecs[3]  = mk(1, 1, 0, 0,   1,   0,   0,  58, 1, 0);
      vecs[4]  = mk(0, 1, 0, 0,   1,   0,   0,  58, 1, 0);
      vecs[5]  = mk(0, 1, 1, 0,   1,   0,   0,  58, 0, 0);
      vecs[6]  = mk(1, 1, 0, 0,   1,   0,   0,  58, 0, 0);
      vecs[7]  = mk(1, 1, 1, 0,   1,   0,   0,  58, 1, 0);
      vecs[8]  = mk(1, 1, 0, 0,   1,   0,   0,  57, 1, 0);
      vecs[9]  = mk(1, 1, 1, 1,   0,   5,   0,   5, 0, 0);
      vecs[10] = mk(0, 0, 0, 0,   0,   5,   0,   0, 0, 0);
      vecs[11] = mk(0, 0, 0, 0, 200, 200,   0,   0, 0, 0);
      vecs[12] = mk(0, 1, 0, 0, 200, 200,  99,  59, 0, 0);
      vecs[13] = mk(0, 1, 0, 0,   0,   0,   0,   0, 0, 0);
      vecs[14] = mk(0, 1, 1, 0,   0,   0,   0,   0, 0, 1);
      vecs[15] = mk(1, 1, 1, 0,   0,   0,   0,   0, 0, 0);
      vecs[16] = mk(0, 1, 0, 1,   0,   2,   0,   2, 0, 0);
      vecs[17] = mk(0, 1, 1, 0,   0,   2,   0,   2, 1, 0);
      vecs[18] = mk(1, 1, 0, 0,   0,   2,   0,   1, 1, 0);
      vecs[19] = mk(1, 1, 0, 0,   0,   2,   0,   0, 0, 1);
      vecs[20] = mk(1, 1, 0, 0,   0,   2,   0,   0, 0, 0);
      vecs[21] = mk(0, 0, 0, 1,   0,   0,   0,   0, 0, 0);
      vecs[22] = mk(0, 0, 1, 0,   0,   0,   0,   0, 1, 0);
      vecs[23] = mk(1, 1, 0, 0,   0,   0,   0,   1, 1, 0);
      vecs[24] = mk(1, 1, 0, 0,   0,   0,   0,   2, 1, 0);

      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", 0, 0, 1'b0, 1'b0);
      rst = 1'b1;

      for (int i = 0; i < 25; i++) begin
         apply(vecs[i].t, vecs[i].m, vecs[i].s, vecs[i].c, vecs[i].pm, vecs[i].ps);
         check($sformatf("vec%0d", i), vecs[i].emin, vecs[i].esec, vecs[i].erun, vecs[i].edone);
      end

      // Stopwatch: 61 ticks from 00:00.
      apply(0, 0, 0, 1, 0, 0);
      apply(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 61; i++) apply(1, 0, 0, 0, 0, 0);
      check("up_61_ticks", 1, 1, 1'b1, 1'b0);

      // Countdown 01:00 to the end.
      apply(0, 1, 0, 1, 1, 0);
      apply(0, 1, 1, 0, 1, 0);
      apply(1, 1, 0, 0, 1, 0);
      check("down_first_tick", 0, 59, 1'b1, 1'b0);
      for (int i = 0; i < 58; i++) apply(1, 1, 0, 0, 1, 0);
      check("down_before_end", 0, 1, 1'b1, 1'b0);
      apply(1, 1, 0, 0, 1, 0);
      check("down_end_pulse", 0, 0, 1'b0, 1'b1);
      apply(1, 1, 1, 0, 1, 0);
      check("done_ignores_ss", 0, 0, 1'b0, 1'b0);

      // Pause holds value through ticks, resume continues.
      apply(0, 1, 0, 1, 1, 0);
      apply(0, 1, 1, 0, 1, 0);
      for (int i = 0; i < 5; i++) apply(1, 1, 0, 0, 1, 0);
      check("pause_pre", 0, 55, 1'b1, 1'b0);
      apply(0, 1, 1, 0, 1, 0);
      for (int i = 0; i < 10; i++) begin
         apply(1, 0, 0, 0, 1, 0);
         check($sformatf("paused_tick%0d", i), 0, 55, 1'b0, 1'b0);
      end
      apply(0, 1, 1, 0, 1, 0);
      check("resume", 0, 55, 1'b1, 1'b0);
      apply(1, 1, 0, 0, 1, 0);
      check("resume_tick", 0, 54, 1'b1, 1'b0);

      // Clear beats start_stop during RUN.
      apply(1, 1, 1, 1, 1, 0);
      check("clear_over_ss", 1, 0, 1'b0, 1'b0);

      // Asynchronous reset mid-run.
      apply(0, 1, 1, 0, 2, 30);
      for (int i = 0; i < 3; i++) apply(1, 1, 0, 0, 2, 30);
      check("pre_reset", 2, 27, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_now", 0, 0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("reset_held", 0, 0, 1'b0, 1'b0);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      apply(0, 1, 0, 0, 2, 30);
      check("after_reset_idle", 2, 30, 1'b0, 1'b0);

      // Stopwatch to its terminal value.
      apply(0, 0, 0, 1, 0, 0);
      apply(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < TMAX - 1; i++) apply(1, 0, 0, 0, 0, 0);
      check("up_before_max", MAXM, MAXS - 1, 1'b1, 1'b0);
      apply(1, 1, 0, 0, 0, 0);
      check("up_max_pulse", MAXM, MAXS, 1'b0, 1'b1);
      apply(1, 0, 0, 0, 0, 0);
      check("up_max_hold", MAXM, MAXS, 1'b0, 1'b0);

      // Random stimulus against the model.
      for (int i = 0; i < 2000; i++) begin
         bit t, m, s, c;
         int pm, ps;
         t  = ($urandom_range(0, 1) == 1);
         m  = ($urandom_range(0, 3) != 0);
         s  = ($urandom_range(0, 7) == 0);
         c  = ($urandom_range(0, 29) == 0);
         pm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 255)) : int'($urandom_range(0, 1));
         ps = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 255)) : int'($urandom_range(0, 5));
         apply(t, m, s, c, pm, ps);
         check_model($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
